// File: rtl/register_file_pkg.sv
// Shared processor datapath definitions: register file geometry, word/index
// types and the 4-input mux cell used to build operand-select trees.
package register_file_pkg;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 5;
  localparam int DEPTH     = 2 ** ADDR_BITS;
  localparam int ZERO_REG  = 0;

  localparam int L1_CELLS  = DEPTH / 4;
  localparam int L2_CELLS  = L1_CELLS / 4;

  typedef logic [WIDTH-1:0]     word_t;
  typedef logic [ADDR_BITS-1:0] addr_t;

  function automatic word_t mux4(input word_t a, input word_t b,
                                 input word_t c, input word_t d,
                                 input logic [1:0] sel);
    word_t y;
    case (sel)
      2'd0:    y = a;
      2'd1:    y = b;
      2'd2:    y = c;
      default: y = d;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/register_file_reg_word.sv
// One architectural register: WIDTH-bit flop with synchronous active-high
// clear and a load enable.
module reg_word
  import register_file_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    q_d = q_q;
    if (load_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values in parallel.
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file.sv
// 32x32 architectural register file: two combinational read ports built from
// 4:1 mux cells, one synchronous write port, register 0 hardwired to zero.
module register_file
  import register_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] read_reg1,
  input  logic [ADDR_BITS-1:0] read_reg2,
  input  logic [ADDR_BITS-1:0] write_reg,
  input  logic [WIDTH-1:0]     write_data,
  input  logic                 reg_write,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2
);

  word_t regs [DEPTH];

  assign regs[ZERO_REG] = '0;

  // Decoder output for index 0 is never built, so r0 can never be loaded.
  for (genvar i = ZERO_REG + 1; i < DEPTH; i++) begin : g_word
    logic load;
    assign load = reg_write && (write_reg == ADDR_BITS'(i));

    reg_word u_word (
      .clk    (clk),
      .reset  (reset),
      .load_i (load),
      .d_i    (write_data),
      .q_o    (regs[i])
    );
  end

  // 32:1 tree: eight 4:1 cells on sel[1:0], two 4:1 cells on sel[3:2], 2:1 on sel[4].
  function automatic word_t read_tree(input word_t words [DEPTH], input addr_t sel);
    word_t l1 [L1_CELLS];
    word_t l2 [L2_CELLS];
    for (int g = 0; g < L1_CELLS; g++) begin
      l1[g] = mux4(words[4*g], words[4*g+1], words[4*g+2], words[4*g+3], sel[1:0]);
    end
    for (int h = 0; h < L2_CELLS; h++) begin
      l2[h] = mux4(l1[4*h], l1[4*h+1], l1[4*h+2], l1[4*h+3], sel[3:2]);
    end
    return sel[4] ? l2[1] : l2[0];
  endfunction

  always_comb begin
    read_data1 = read_tree(regs, read_reg1);
    read_data2 = read_tree(regs, read_reg2);
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: vector table plus hand-written sequences
// for reset sweep, read-during-write and the full-population sweep.
module tb_register_file;
  import register_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] read_data1, read_data2;

  int n_checks = 0;
  int n_fail   = 0;

  register_file dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] rr1, input logic [4:0] rr2);
    reset = rst; reg_write = we; write_reg = wr; write_data = wd;
    read_reg1 = rr1; read_reg2 = rr2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Expected values are the read ports observed after the vector's edge.
    vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd4,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 5'd6,  32'h0BADF00D, 5'd6,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 1'b1, 5'd7,  32'hAAAA5555, 5'd7,  5'd5,  32'hAAAA5555, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 5'd3,  32'h11111111, 5'd3,  5'd7,  32'h0,        32'hAAAA5555};
    vecs[5] = '{1'b1, 1'b1, 5'd3,  32'h22222222, 5'd3,  5'd5,  32'h0,        32'h0};
    vecs[6] = '{1'b0, 1'b1, 5'd3,  32'h33333333, 5'd3,  5'd7,  32'h33333333, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 5'd3,  32'h44444444, 5'd3,  5'd3,  32'h44444444, 32'h44444444};
    vecs[8] = '{1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};
    vecs[9] = '{1'b0, 1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hFFFFFFFF};

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    for (int i = 0; i < DEPTH; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(DEPTH - 1 - i);
      #1;
      check($sformatf("reset_rd1_r%0d", i), read_data1, 32'h0);
      check($sformatf("reset_rd2_r%0d", DEPTH - 1 - i), read_data2, 32'h0);
    end

    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].rr1, vecs[v].rr2);
      tick();
      check($sformatf("vec%0d_rd1", v), read_data1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), read_data2, vecs[v].exp2);
    end

    drive(1'b0, 1'b1, 5'd7, 32'hAAAA5555, 5'd0, 5'd7);
    tick();
    drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd7);
    #1;
    check("rdw_before_edge", read_data2, 32'hAAAA5555);
    tick();
    check("rdw_after_edge", read_data2, 32'h12345678);

    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'h01010101 * 32'(i), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < DEPTH; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(DEPTH - 1 - i);
      #1;
      check($sformatf("sweep_rd1_r%0d", i), read_data1, 32'h01010101 * 32'(i));
      check($sformatf("sweep_rd2_r%0d", DEPTH - 1 - i), read_data2,
            32'h01010101 * 32'(DEPTH - 1 - i));
    end

    drive(1'b1, 1'b1, 5'd9, 32'h99999999, 5'd9, 5'd17);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd17);
    #1;
    check("midreset_r9", read_data1, 32'h0);
    check("midreset_r17", read_data2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file for the single-cycle processor: 32 general-purpose registers of 32 bits, two combinational read ports and one synchronous write port. It sits directly upstream of the operand-select multiplexers: read_data1/read_data2 feed the ALU-input and result-select mux trees. It is written back from the result-select mux output on the clock edge that ends each instruction.

## Interface
- WIDTH, 32, data width of each register
- ADDR_BITS, 5, register index width; depth = 2**ADDR_BITS
- clk  input  1  single system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- read_reg1  input  ADDR_BITS  index for read port 1
- read_reg2  input  ADDR_BITS  index for read port 2
- write_reg  input  ADDR_BITS  index for write port
- write_data  input  WIDTH  data to write
- reg_write  input  1  write enable
- read_data1  output  WIDTH  contents of register read_reg1
- read_data2  output  WIDTH  contents of register read_reg2

## Operation
- Storage: 2**ADDR_BITS registers, each WIDTH bits; register 0 is hardwired zero.
- Reset: on a rising edge with reset=1, every register is cleared to 0. reset has priority over reg_write in the same cycle; the write is dropped.
- Write: on a rising edge with reset=0 and reg_write=1, register[write_reg] <= write_data. This is suppressed when write_reg=0, and register 0 stays 0.
- reg_write=0: no register changes. write_reg and write_data are don't-care.
- Read: read_dataN = register[read_regN], purely combinational with no clock involvement. Index 0 always returns 0.
- Both read ports are independent. The same index on both ports returns identical data.
- Write decode: a one-hot decoder gated by reg_write selects exactly one register load-enable. No enable is ever asserted for index 0.
- No X propagation: every register holds a defined value from the first reset onward. Read indices are always in range because depth equals 2**ADDR_BITS.

## Timing
- Read latency: 0 cycles (combinational from read_regN and register state).
- Write latency: 1 edge. The new value is visible on a read port in the cycle after the write edge.
- Read-during-write to the same index in the same cycle: the read port returns the OLD value until the edge, then the new value. There is no internal bypass; the single-cycle datapath does not need one.
- Outputs after reset: read_data1 = read_data2 = 0 for every index.
- Reset asserted mid-program: all registers read 0 from the cycle after the reset edge. Any concurrent write is lost.
- Back-to-back writes to the same index on consecutive edges: the last one wins. Each edge commits independently.

## Structure
- Constants WIDTH=32, ADDR_BITS=5 and the zero-register index live in the shared processor definitions include used by the datapath, not locally.
- Sub-module `reg_word`: a WIDTH-bit register with clk, reset (sync, active-high), load enable, d and q. It is instantiated for indices 1..2**ADDR_BITS-1. Index 0 is a constant-zero net.
- Read ports use WIDTH-bit wide 2**ADDR_BITS:1 mux trees, built from the datapath's existing 4-input mux cells: a 32:1 mux is two levels of 4:1 cells plus a final 2:1 level.
- Write decoder: 5-to-32 one-hot, ANDed with reg_write.

## Test plan
- Reset state: assert reset for 1 edge, then sweep read_reg1/read_reg2 over 0..31 -> both ports read 0x00000000 for every index.
- Basic write/read: write 0xDEADBEEF to r5 with reg_write=1 -> read_reg1=5 shows 0xDEADBEEF after the edge. r4 and r6 remain 0.
- Zero register: write 0xFFFFFFFF to r0 -> read_data1 with read_reg1=0 stays 0x00000000.
- Read-during-write: read_reg2=7 while writing 0x12345678 to r7 (old value 0xAAAA5555) -> before the edge read_data2=0xAAAA5555; after the edge read_data2=0x12345678.
- Enable gating and priority:
  - write 0x11111111 to r3 with reg_write=0 -> r3 unchanged.
  - reset=1 with reg_write=1, write_reg=3, data 0x22222222 -> r3 reads 0.
- Full sweep: write value 0x01010101*i to each ri, i=1..31, then read port 1 = ri and port 2 = r(31-i) simultaneously -> each port returns its own index's value, and r0 = 0.
